// File: rtl/data_bus_responder.sv
// Data-port responder for the RV32 core: word RAM, GPIO, cycle counter and a TX byte FIFO
// with a valid/ready drain port. Reads are combinational; writes land on the rising edge.
module data_bus_responder #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic [31:0] gpio_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [31:0]   gpio_q, gpio_d;
    logic [31:0]   cycle_q;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          ram_sel, mmio_sel;
    logic [1:0]    reg_idx;
    logic [AW-1:0] ram_idx;
    logic          full, pop, push_req, push_ok;
    logic [31:0]   status;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^mem_addr_i[1:0];

    assign ram_sel  = ~mem_addr_i[31];
    assign mmio_sel = mem_addr_i[31] & (mem_addr_i[30:4] == '0);
    assign reg_idx  = mem_addr_i[3:2];
    assign ram_idx  = mem_addr_i[AW+1:2];

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = tx_valid_o & tx_ready_i;
    assign push_req = mem_we_i & mmio_sel & (reg_idx == 2'd2);
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop);

    assign status     = {16'h0, 8'(count_q), 5'h0, ovf_q, full, (count_q == '0)};
    assign tx_valid_o = (count_q != '0);
    assign tx_data_o  = fifo_q[rd_ptr_q];
    assign gpio_o     = gpio_q;

    always_comb begin
        mem_data_o = 32'h0;
        if (ram_sel) begin
            mem_data_o = ram_q[ram_idx];
        end else if (mmio_sel) begin
            case (reg_idx)
                2'd0:    mem_data_o = gpio_q;
                2'd1:    mem_data_o = cycle_q;
                2'd3:    mem_data_o = status;
                default: mem_data_o = 32'h0;
            endcase
        end
    end

    always_comb begin
        gpio_d   = gpio_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_q;
        if (mem_we_i && mmio_sel && reg_idx == 2'd0) begin
            gpio_d = mem_data_i;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        // Setting overflow wins over a clear issued in the same cycle.
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (mem_we_i && mmio_sel && reg_idx == 2'd3 && mem_data_i[2]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gpio_q   <= 32'h0;
            cycle_q  <= 32'h0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            gpio_q   <= gpio_d;
            cycle_q  <= cycle_q + 32'd1;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage arrays carry no reset; RAM contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we_i && ram_sel) begin
            ram_q[ram_idx] <= mem_data_i;
        end
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= mem_data_i[7:0];
        end
    end
endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed scenarios followed by random bus traffic,
// all compared against a queue-based behavioural model of the address map.
module tb_data_bus_responder;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [31:0] gpio;
    logic [7:0]  txd;
    logic        txv;
    logic        ready = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [31:0] m_gpio;
    logic [31:0] m_cycle;
    logic [7:0]  m_q [$];
    logic        m_ovf;

    data_bus_responder #(.RAM_WORDS(1024), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .mem_we_i(we), .mem_addr_i(addr),
        .mem_data_i(wdata), .mem_data_o(rdata), .gpio_o(gpio),
        .tx_data_o(txd), .tx_valid_o(txv), .tx_ready_i(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_gpio  = 32'h0;
        m_cycle = 32'h0;
        m_q.delete();
        m_ovf   = 1'b0;
    endtask

    function automatic logic [31:0] m_status();
        return {16'h0, 8'(m_q.size()), 5'h0, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0)};
    endfunction

    // Returns 1 when the model knows what this address reads.
    function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
        int idx;
        v = 32'h0;
        if (!a[31]) begin
            idx = int'(a[11:2]);
            if (!m_ram.exists(idx)) return 1'b0;
            v = m_ram[idx];
        end else if (a[30:4] == 27'h0) begin
            case (a[3:2])
                2'd0: v = m_gpio;
                2'd1: v = m_cycle;
                2'd2: v = 32'h0;
                2'd3: v = m_status();
            endcase
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
        bit is_mmio, pushreq, popping, accept;
        is_mmio = a[31] && (a[30:4] == 27'h0);
        if (w && !a[31]) m_ram[int'(a[11:2])] = d;
        if (w && is_mmio && a[3:2] == 2'd0) m_gpio = d;
        pushreq = w && is_mmio && a[3:2] == 2'd2;
        popping = r && (m_q.size() > 0);
        accept  = pushreq && (m_q.size() < DEPTH || popping);
        if (w && is_mmio && a[3:2] == 2'd3 && d[2]) m_ovf = 1'b0;
        if (pushreq && !accept) m_ovf = 1'b1;
        if (popping) void'(m_q.pop_front());
        if (accept) m_q.push_back(d[7:0]);
        m_cycle = m_cycle + 32'd1;
    endtask

    // Called at a falling edge; drives one bus cycle, checks, and returns at the next falling edge.
    task automatic do_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic r, output logic [31:0] rd);
        logic [31:0] exp;
        we = w; addr = a; wdata = d; ready = r;
        #1;
        rd = rdata;
        if (m_read(a, exp)) chk("rdata", rdata, exp);
        chk("gpio", gpio, m_gpio);
        chk("tx_valid", {31'h0, txv}, {31'h0, (m_q.size() > 0)});
        if (m_q.size() > 0) chk("tx_data", {24'h0, txd}, {24'h0, m_q[0]});
        model_edge(w, a, d, r);
        @(negedge clk);
    endtask

    task automatic idle(input logic r, output logic [31:0] rd);
        do_cycle(1'b0, 32'h8000_0004, 32'h0, r, rd);
    endtask

    logic [31:0] rd;
    logic [31:0] a_r;

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_gpio", gpio, 32'h0);
        chk("rst_txv", {31'h0, txv}, 32'h0);
        rst = 1'b0;

        // Counter reads 0,1,2 straight after release; status is empty.
        idle(1'b0, rd); chk("cycle0", rd, 32'h0);
        idle(1'b0, rd); chk("cycle1", rd, 32'h1);
        idle(1'b0, rd); chk("cycle2", rd, 32'h2);
        do_cycle(1'b0, 32'h8000_000C, 32'h0, 1'b0, rd); chk("status_rst", rd, 32'h1);

        // RAM write, aliasing and unmapped read.
        do_cycle(1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, rd);
        do_cycle(1'b0, 32'h0000_0010, 32'h0, 1'b0, rd); chk("ram_rd", rd, 32'hDEADBEEF);
        do_cycle(1'b0, 32'h0000_1010, 32'h0, 1'b0, rd); chk("ram_alias", rd, 32'hDEADBEEF);
        do_cycle(1'b0, 32'h8000_0010, 32'h0, 1'b0, rd); chk("unmapped", rd, 32'h0);
        do_cycle(1'b1, 32'h8000_0010, 32'h1234, 1'b0, rd);

        // GPIO and read-only CYCLE.
        do_cycle(1'b1, 32'h8000_0000, 32'hA5, 1'b0, rd);
        chk("gpio_a5", gpio, 32'hA5);
        idle(1'b0, a_r);
        do_cycle(1'b1, 32'h8000_0004, 32'h0, 1'b0, rd);
        idle(1'b0, rd); chk("cycle_ro", rd, a_r + 32'd2);

        // Nine pushes into an 8-deep FIFO with the sink stalled.
        for (int i = 0; i < 9; i++) do_cycle(1'b1, 32'h8000_0008, 32'h11 + i, 1'b0, rd);
        do_cycle(1'b0, 32'h8000_000C, 32'h0, 1'b0, rd); chk("status_ovf", rd, 32'h0806);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", {24'h0, txd}, 32'h11 + i);
            do_cycle(1'b0, 32'h8000_000C, 32'h0, 1'b1, rd);
        end
        do_cycle(1'b0, 32'h8000_000C, 32'h0, 1'b1, rd); chk("status_empty_ovf", rd, 32'h5);
        do_cycle(1'b1, 32'h8000_000C, 32'h4, 1'b0, rd);
        do_cycle(1'b0, 32'h8000_000C, 32'h0, 1'b0, rd); chk("status_clr", rd, 32'h1);

        // Push into a full FIFO while the head is popped.
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 32'h8000_0008, 32'h60 + i, 1'b0, rd);
        do_cycle(1'b1, 32'h8000_0008, 32'h77, 1'b1, rd);
        do_cycle(1'b0, 32'h8000_000C, 32'h0, 1'b0, rd); chk("status_full_pp", rd, 32'h0802);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("last_77", {24'h0, txd}, 32'h77);
            do_cycle(1'b0, 32'h8000_000C, 32'h0, 1'b1, rd);
        end

        // Asynchronous reset with bytes queued.
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h8000_0008, 32'hC0 + i, 1'b0, rd);
        chk("pre_rst_txv", {31'h0, txv}, 32'h1);
        we = 1'b0; addr = 32'h0000_0010; ready = 1'b0;
        #2 rst = 1'b1;
        #1 chk("async_txv", {31'h0, txv}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        do_cycle(1'b0, 32'h0000_0010, 32'h0, 1'b0, rd); chk("ram_survive", rd, 32'hDEADBEEF);
        do_cycle(1'b0, 32'h8000_000C, 32'h0, 1'b0, rd); chk("status_post_rst", rd, 32'h1);

        // Seed a small RAM window so random reads always hit known words.
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 32'(i) << 2, $urandom, 1'b0, rd);

        for (int n = 0; n < 400; n++) begin
            logic w;
            logic [31:0] a, d;
            w = ($urandom_range(0, 1) == 1);
            d = $urandom;
            case ($urandom_range(0, 6))
                0: a = {1'b0, 19'($urandom), 6'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
                1: a = 32'h8000_0000 | 32'($urandom_range(0, 3));
                2: a = 32'h8000_0004 | 32'($urandom_range(0, 3));
                3, 4: a = 32'h8000_0008 | 32'($urandom_range(0, 3));
                5: a = 32'h8000_000C | 32'($urandom_range(0, 3));
                default: a = {1'b1, 27'($urandom_range(1, 32'h7FF_FFFF)), 4'($urandom)};
            endcase
            do_cycle(w, a, d, ($urandom_range(0, 2) == 0), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Memory-mapped responder for the single-cycle RV32 core's data port: accepts the core's write strobe, address and write data, and returns read data in the same cycle. It decodes a word-addressed RAM region and four MMIO registers: GPIO output, free-running cycle counter, TX byte FIFO push and TX status. The TX FIFO drains bytes through a valid/ready stream toward a future UART transmitter. It sits between the core's data bus and the SoC peripherals.

## Interface
- RAM_WORDS, 1024, RAM depth in 32-bit words (power of 2); address bits used = clog2(RAM_WORDS)+2
- FIFO_DEPTH, 8, TX FIFO depth in bytes (power of 2, 2..128)
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- mem_we_i  input  1  write strobe from core
- mem_addr_i  input  32  byte address from core (addr[1:0] ignored, word access only)
- mem_data_i  input  32  write data from core
- mem_data_o  output  32  read data to core, combinational from mem_addr_i
- gpio_o  output  32  GPIO output register
- tx_data_o  output  8  FIFO head byte
- tx_valid_o  output  1  FIFO non-empty
- tx_ready_i  input  1  downstream accepts byte

## Operation
- Decode: addr[31]=0 -> RAM, index addr[clog2(RAM_WORDS)+1:2]; higher bits are ignored, so the region aliases. addr[31]=1 with addr[30:4]=0 -> MMIO selected by addr[3:2]. Anything else is unmapped: reads 0, writes ignored.
- 0x8000_0000 GPIO: R/W, write loads gpio_o.
- 0x8000_0004 CYCLE: read-only 32-bit counter, +1 every clock, wraps 0xFFFF_FFFF->0; writes ignored.
- 0x8000_0008 TXDATA: write pushes mem_data_i[7:0]; reads 0.
- 0x8000_000C STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] count, other bits 0. A write with data bit2=1 clears overflow; other bits are ignored.
- RAM: synchronous write when mem_we_i, asynchronous read. Not reset; contents survive rst_i.
- FIFO: circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - Pop = tx_valid_o & tx_ready_i.
  - Push request = mem_we_i & TXDATA selected.
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A rejected push drops the byte and sets overflow. Overflow set has priority over clear in the same cycle.
  - Simultaneous push and pop leaves count unchanged, both pointers advance.
- tx_valid_o = (count!=0); tx_data_o = buffer[rd_ptr]. tx_data_o must hold stable while tx_valid_o=1 and no pop occurs.

## Timing
- Read latency 0: mem_data_o reflects mem_addr_i and current state in the same cycle.
- Write takes effect at the rising edge where mem_we_i=1; read-after-write returns the new value from the next cycle onward.
- CYCLE read returns the pre-edge value. The first cycle after rst_i deasserts reads 0, the next reads 1.
- STATUS read after a push reflects it in the next cycle. A pop is visible in STATUS in the cycle after the handshake.
- Reset values (applied asynchronously):
  - gpio_o=0, CYCLE=0, FIFO pointers/count=0, overflow=0.
  - tx_valid_o=0, tx_data_o=don't-care.
  - STATUS reads 0x0000_0001.
- Reset mid-stream: tx_valid_o drops immediately without waiting for a clock, and queued bytes are discarded.
- tx_ready_i with an empty FIFO has no effect.

## Test plan
- Reset, then release: gpio_o=0, tx_valid_o=0, STATUS reads 0x0000_0001; CYCLE reads 0, 1, 2 on consecutive cycles.
- Write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 next cycle -> 0xDEADBEEF; read alias 0x0000_1010 (RAM_WORDS=1024) -> 0xDEADBEEF; read 0x8000_0010 -> 0.
- Write 0x0000_00A5 to GPIO -> gpio_o=0x0000_00A5 after the edge; write to CYCLE -> counter unaffected.
- tx_ready_i=0, push 0x11..0x19 (9 bytes) -> STATUS=0x0000_0806 (count 8, full, overflow); enable tx_ready_i -> bytes 0x11..0x18 emerge in order, one per cycle; then STATUS=0x0000_0005; write 0x4 to STATUS -> 0x0000_0001.
- FIFO full with tx_ready_i=1 and a push of 0x77 in the same cycle -> push accepted, count stays 8, overflow stays 0, and 0x77 emerges last.
- Assert rst_i asynchronously with 3 bytes queued -> tx_valid_o=0 before the next edge; RAM word at 0x10 still reads 0xDEADBEEF.
